// File: rtl/tmod_cmd_master.sv
// tmod_cmd_master: queued, multi-channel command master for the temperature-monitor bus.
// Define TMOD_TIMEOUT_EN to enable the ISSUE-state ready timeout (TIMEOUT cycles).

package tmod_cmd_master_pkg;
   typedef enum logic [1:0] {
      TMOD_NOOP          = 2'd0,
      TMOD_RESET         = 2'd1,
      TMOD_SET_FRQ       = 2'd2,
      TMOD_SET_HIGH_TEMP = 2'd3
   } tmod_op_e;
endpackage

module tmod_cmd_master
   import tmod_cmd_master_pkg::*;
#(
   parameter  int unsigned DW      = 8,
   parameter  int unsigned DEPTH   = 4,
   parameter  int unsigned NCH     = 2,
   parameter  int unsigned TIMEOUT = 16,
   localparam int unsigned CW      = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int unsigned NW      = $clog2(DEPTH + 1)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [1:0]     req_op,
   input  logic [CW-1:0]  req_ch,
   input  logic [DW-1:0]  req_data,
   output logic           done,
   output logic           err,
   output logic           busy,
   output logic [NW-1:0]  count,
   output logic           m_valid,
   output logic [1:0]     m_op,
   output logic [DW-1:0]  m_opnd,
   output logic [NCH-1:0] m_sel,
   input  logic [NCH-1:0] m_ready
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic {ST_IDLE, ST_ISSUE} state_e;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("tmod_cmd_master: DEPTH must be a power of 2 and >= 2");
   end
   if (NCH < 1) begin : g_bad_nch
      $error("tmod_cmd_master: NCH must be >= 1");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("tmod_cmd_master: TIMEOUT must be >= 1");
   end

   // ---------------------------------------------------------------- FIFO
   logic [1:0]    r_mem_op   [DEPTH];
   logic [CW-1:0] r_mem_ch   [DEPTH];
   logic [DW-1:0] r_mem_data [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [NW-1:0] r_count;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   tmod_op_e      w_head_op;
   logic [CW-1:0] w_head_ch;
   logic [DW-1:0] w_head_data;

   assign w_full      = (r_count == NW'(DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_push      = req_valid && !w_full;
   assign w_head_op   = tmod_op_e'(r_mem_op[r_rd_ptr]);
   assign w_head_ch   = r_mem_ch[r_rd_ptr];
   assign w_head_data = r_mem_data[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_op[r_wr_ptr]   <= req_op;
         r_mem_ch[r_wr_ptr]   <= req_ch;
         r_mem_data[r_wr_ptr] <= req_data;
      end
   end

   // DEPTH is a power of 2, so pointer wrap is the natural AW-bit rollover
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + NW'(1);
            2'b01:   r_count <= r_count - NW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ---------------------------------------------------------------- FSM
   state_e         r_state;
   state_e         w_state_nxt;
   logic           r_m_valid;
   tmod_op_e       r_m_op;
   logic [DW-1:0]  r_m_opnd;
   logic [NCH-1:0] r_m_sel;
   logic           r_done;
   logic           r_err;

   logic           w_ch_bad;
   logic [NCH-1:0] w_onehot;
   logic [NCH-1:0] w_sel_nxt;
   logic           w_complete;
   logic           w_timeout;
   logic           w_load;
   logic           w_leave;
   logic           w_done_nxt;
   logic           w_err_nxt;

   assign w_ch_bad   = (32'(w_head_ch) >= NCH);
   assign w_complete = ((m_ready & r_m_sel) == r_m_sel);

   always_comb begin
      w_onehot = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         w_onehot[i] = (32'(w_head_ch) == i);
      end
   end

`ifdef TMOD_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] r_wait;

   assign w_timeout = (r_wait == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait <= '0;
      end else if (w_load) begin
         r_wait <= '0;
      end else if (r_state == ST_ISSUE && !w_complete) begin
         r_wait <= r_wait + TW'(1);
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_load      = 1'b0;
      w_leave     = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_sel_nxt   = w_onehot;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop = 1'b1;
               if (w_head_op == TMOD_NOOP) begin
                  w_done_nxt = 1'b1;
               end else if (w_head_op == TMOD_RESET) begin
                  w_load      = 1'b1;
                  w_sel_nxt   = '1;
                  w_state_nxt = ST_ISSUE;
               end else if (w_ch_bad) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_load      = 1'b1;
                  w_state_nxt = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            // completion wins over a timeout landing on the same edge
            if (w_complete) begin
               w_done_nxt  = 1'b1;
               w_leave     = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (w_timeout) begin
               w_err_nxt   = 1'b1;
               w_leave     = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // bus holding registers double as the popped command; opnd/sel keep their last values
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_m_valid <= 1'b0;
         r_m_op    <= TMOD_NOOP;
         r_m_opnd  <= '0;
         r_m_sel   <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_done <= w_done_nxt;
         r_err  <= w_err_nxt;
         if (w_load) begin
            r_m_valid <= 1'b1;
            r_m_op    <= w_head_op;
            r_m_opnd  <= w_head_data;
            r_m_sel   <= w_sel_nxt;
         end else if (w_leave) begin
            r_m_valid <= 1'b0;
            r_m_op    <= TMOD_NOOP;
         end
      end
   end

   assign req_ready = !w_full;
   assign done      = r_done;
   assign err       = r_err;
   assign busy      = (r_state != ST_IDLE) || !w_empty;
   assign count     = r_count;
   assign m_valid   = r_m_valid;
   assign m_op      = r_m_op;
   assign m_opnd    = r_m_opnd;
   assign m_sel     = r_m_sel;

endmodule

// File: tb/tb_tmod_cmd_master.sv
// Scoreboard bench for tmod_cmd_master: transaction-level model feeds expected pulses/issues,
// a negedge monitor pops and compares. Honours TMOD_TIMEOUT_EN when defined.

module tb_tmod_cmd_master;
   import tmod_cmd_master_pkg::*;

   localparam int unsigned DW      = 8;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned NCH     = 3;
   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned CW      = 2;
   localparam int unsigned NW      = 3;
`ifdef TMOD_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef logic [NCH-1:0] sel_t;
   typedef struct packed {
      logic [1:0]    op;
      logic [CW-1:0] ch;
      logic [DW-1:0] data;
   } cmd_t;
   typedef struct {
      bit          is_err;
      int unsigned cyc;
   } resp_t;
   typedef struct {
      logic [1:0]    op;
      logic [DW-1:0] opnd;
      sel_t          sel;
      int unsigned   cyc;
   } bus_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_op;
   logic [CW-1:0] req_ch;
   logic [DW-1:0] req_data;
   logic          done;
   logic          err;
   logic          busy;
   logic [NW-1:0] count;
   logic          m_valid;
   logic [1:0]    m_op;
   logic [DW-1:0] m_opnd;
   sel_t          m_sel;
   sel_t          m_ready;

   always #5 clk = ~clk;

   tmod_cmd_master #(
      .DW      (DW),
      .DEPTH   (DEPTH),
      .NCH     (NCH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_ch    (req_ch),
      .req_data  (req_data),
      .done      (done),
      .err       (err),
      .busy      (busy),
      .count     (count),
      .m_valid   (m_valid),
      .m_op      (m_op),
      .m_opnd    (m_opnd),
      .m_sel     (m_sel),
      .m_ready   (m_ready)
   );

   int          errors = 0;
   int          checks = 0;
   int unsigned cyc    = 0;

   cmd_t          mq[$];
   resp_t         rq[$];
   bus_t          bq[$];
   bit            act;
   bus_t          cur;
   int unsigned   act_wait;
   logic [DW-1:0] last_opnd;
   sel_t          last_sel;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      rq.delete();
      bq.delete();
      act       = 1'b0;
      act_wait  = 0;
      last_opnd = '0;
      last_sel  = '0;
   endtask

   // One clock of the queued master, described as command transactions.
   task automatic model_step();
      int unsigned n;
      cmd_t        c;
      resp_t       r;
      n = mq.size();
      if (act) begin
         if ((m_ready & cur.sel) == cur.sel) begin
            r.is_err = 1'b0; r.cyc = cyc; rq.push_back(r);
            act = 1'b0;
         end else if (TO_EN && (act_wait + 1 == TIMEOUT)) begin
            r.is_err = 1'b1; r.cyc = cyc; rq.push_back(r);
            act = 1'b0;
         end else begin
            act_wait++;
         end
      end else if (n != 0) begin
         c = mq.pop_front();
         if (c.op == TMOD_NOOP) begin
            r.is_err = 1'b0; r.cyc = cyc; rq.push_back(r);
         end else if (c.op != TMOD_RESET && c.ch >= NCH) begin
            r.is_err = 1'b1; r.cyc = cyc; rq.push_back(r);
         end else begin
            cur.op   = c.op;
            cur.opnd = c.data;
            cur.sel  = (c.op == TMOD_RESET) ? '1 : (sel_t'(1) << c.ch);
            cur.cyc  = cyc;
            bq.push_back(cur);
            act       = 1'b1;
            act_wait  = 0;
            last_opnd = c.data;
            last_sel  = cur.sel;
         end
      end
      if (req_valid && n < DEPTH) begin
         c.op = req_op; c.ch = req_ch; c.data = req_data;
         mq.push_back(c);
      end
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk);
         cyc++;
         if (reset) model_clear();
         else model_step();
      end
   end

   initial begin
      logic  pv;
      resp_t r;
      bus_t  b;
      pv = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            chk("rst_req_ready", 32'(req_ready), 1);
            chk("rst_done", 32'(done), 0);
            chk("rst_err", 32'(err), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_count", 32'(count), 0);
            chk("rst_m_valid", 32'(m_valid), 0);
            chk("rst_m_op", 32'(m_op), 32'(TMOD_NOOP));
            chk("rst_m_opnd", 32'(m_opnd), 0);
            chk("rst_m_sel", 32'(m_sel), 0);
            model_clear();
            pv = 1'b0;
         end else begin
            chk("count", 32'(count), 32'(mq.size()));
            chk("req_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
            chk("busy", 32'(busy), 32'(act || mq.size() != 0));
            chk("m_valid", 32'(m_valid), 32'(act));
            chk("done_err_excl", 32'(done & err), 0);
            if (done || err) begin
               if (rq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none (cycle %0d)", done, err, cyc);
               end else begin
                  r = rq.pop_front();
                  chk("resp_is_err", 32'(err), 32'(r.is_err));
                  chk("resp_cycle", cyc, r.cyc);
               end
            end
            while (rq.size() != 0 && rq[0].cyc < cyc) begin
               r = rq.pop_front();
               checks++; errors++;
               $display("FAIL missing_pulse: got none expected %s at cycle %0d", r.is_err ? "err" : "done", r.cyc);
            end
            if (m_valid && !pv) begin
               if (bq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_issue: got m_valid=1 op=%0d expected none (cycle %0d)", m_op, cyc);
               end else begin
                  b = bq.pop_front();
                  chk("issue_op", 32'(m_op), 32'(b.op));
                  chk("issue_opnd", 32'(m_opnd), 32'(b.opnd));
                  chk("issue_sel", 32'(m_sel), 32'(b.sel));
                  chk("issue_cycle", cyc, b.cyc);
               end
            end
            if (act) begin
               chk("hold_op", 32'(m_op), 32'(cur.op));
               chk("hold_opnd", 32'(m_opnd), 32'(cur.opnd));
               chk("hold_sel", 32'(m_sel), 32'(cur.sel));
            end else begin
               chk("idle_op", 32'(m_op), 32'(TMOD_NOOP));
               chk("idle_opnd", 32'(m_opnd), 32'(last_opnd));
               chk("idle_sel", 32'(m_sel), 32'(last_sel));
            end
            pv = m_valid;
         end
      end
   end

   task automatic idle(input int unsigned n, input sel_t rdy);
      for (int unsigned i = 0; i < n; i++) begin
         req_valid = 1'b0;
         m_ready   = rdy;
         @(posedge clk); #1;
      end
   endtask

   task automatic push(input logic [1:0] op, input logic [CW-1:0] ch, input logic [DW-1:0] d,
                       input sel_t rdy);
      req_valid = 1'b1;
      req_op    = op;
      req_ch    = ch;
      req_data  = d;
      m_ready   = rdy;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_op    = '0;
      req_ch    = '0;
      req_data  = '0;
      m_ready   = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // single command, selected channel ready
      push(TMOD_SET_FRQ, 2'd1, 8'h3C, 3'b010);
      idle(4, 3'b010);

      // fill the FIFO behind a stalled command, try pushing while full, then drain
      for (int unsigned i = 0; i < 5; i++) begin
         push(TMOD_SET_HIGH_TEMP, CW'(i % 3), DW'(8'h10 + i), 3'b000);
      end
      push(TMOD_SET_FRQ, 2'd0, 8'hEE, 3'b000);
      push(TMOD_SET_FRQ, 2'd2, 8'hEF, 3'b000);
      idle(16, 3'b111);

      // broadcast waits for every channel at the same edge
      push(TMOD_RESET, 2'd2, 8'hA5, 3'b011);
      idle(3, 3'b011);
      idle(4, 3'b111);

      // bad channel then NOOP: back-to-back err and done, no bus activity
      push(TMOD_SET_HIGH_TEMP, 2'd3, 8'h42, 3'b000);
      push(TMOD_NOOP, 2'd3, 8'h00, 3'b000);
      idle(4, 3'b000);

      // stalled channel: times out when enabled, otherwise waits until ready
      push(TMOD_SET_FRQ, 2'd0, 8'h77, 3'b000);
      push(TMOD_SET_HIGH_TEMP, 2'd2, 8'h55, 3'b000);
      idle(22, 3'b000);
      idle(6, 3'b111);

      // reset while ISSUE is in flight with commands queued
      push(TMOD_SET_FRQ, 2'd1, 8'h11, 3'b000);
      push(TMOD_SET_FRQ, 2'd2, 8'h22, 3'b000);
      push(TMOD_SET_HIGH_TEMP, 2'd0, 8'h33, 3'b000);
      idle(1, 3'b000);
      reset = 1'b1;
      idle(2, 3'b000);
      reset = 1'b0;
      idle(3, 3'b111);

      // random traffic, mostly-ready channels then mostly-stalled channels
      for (int unsigned i = 0; i < 500; i++) begin
         req_valid = ($urandom_range(0, 2) != 0);
         req_op    = 2'($urandom);
         req_ch    = CW'($urandom);
         req_data  = DW'($urandom);
         m_ready   = sel_t'($urandom) | sel_t'($urandom);
         @(posedge clk); #1;
      end
      for (int unsigned i = 0; i < 300; i++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_op    = 2'($urandom);
         req_ch    = CW'($urandom);
         req_data  = DW'($urandom);
         m_ready   = sel_t'($urandom) & sel_t'($urandom);
         @(posedge clk); #1;
      end
      idle(60, 3'b111);

      chk("leftover_resp", 32'(rq.size()), 0);
      chk("leftover_issue", 32'(bq.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tmod_cmd_master.md
# tmod_cmd_master

Queued, multi-channel command master for the temperature-monitor bus. It accepts TMOD_OP requests from the controlling logic through a valid/ready port and buffers them in a DEPTH-entry FIFO. It issues each request to one of NCH monitor channels, or to all channels at once, using a valid/ready handshake. Each command ends with a one-cycle `done` or `err` pulse. It replaces the single-request, unbuffered master, which had no flow control.

## Interface
- `DW`, 8: operand width (bits).
- `DEPTH`, 4: command FIFO entries. Must be a power of 2 and ≥2.
- `NCH`, 2: number of monitor channels. Must be ≥1. `CW = (NCH>1) ? $clog2(NCH) : 1`.
- `TIMEOUT`, 16: maximum number of cycles to wait for a channel's ready. Must be ≥1. Used only with `TMOD_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  FIFO can accept. Equals `!full`.
- `req_op`  in  TMOD_OP  requested opcode.
- `req_ch`  in  CW  target channel.
- `req_data`  in  DW  operand.
- `done`  out  1  one-cycle pulse: command completed.
- `err`  out  1  one-cycle pulse: command dropped.
- `busy`  out  1  FSM is not IDLE, or the FIFO is not empty.
- `count`  out  $clog2(DEPTH+1)  FIFO occupancy.
- `m_valid`  out  1  bus command valid.
- `m_op`  out  TMOD_OP  bus opcode.
- `m_opnd`  out  DW  bus operand.
- `m_sel`  out  NCH  one-hot channel select. All ones for broadcast RESET.
- `m_ready`  in  NCH  per-channel ready.

## Operation
- **Push:** a request is written on each edge where `req_valid && req_ready`. A push into a full FIFO cannot occur, because `req_ready` is low. A simultaneous push and pop while full is not accepted: `req_ready` comes from `full` only, with no pass-through.
- **FSM states:** IDLE, ISSUE.
- **IDLE:** if the FIFO is non-empty, pop the head into the holding registers, then decode it:
  - `NOOP`: `done` pulses, stay in IDLE, no bus activity.
  - `req_ch >= NCH` (any op except RESET): `err` pulses, stay in IDLE, no bus activity.
  - `RESET`: `m_sel` = all ones; go to ISSUE.
  - `SET_FRQ` or `SET_HIGH_TEMP`: `m_sel` = one-hot(`ch`); go to ISSUE.
- **ISSUE:** `m_valid`=1. `m_op`, `m_opnd` and `m_sel` are held stable until the command completes.
  - Completion condition: `(m_ready & m_sel) == m_sel`, sampled at an edge. This means the selected channel is ready, or, for a broadcast, every channel is ready at the same edge.
  - On completion: `done` pulses, go to IDLE.
  - Timeout (`TMOD_TIMEOUT_EN` only): a wait counter clears on entry to ISSUE and increments every ISSUE cycle without completion. When it reaches TIMEOUT, `err` pulses, the command is discarded and the FSM goes to IDLE.
- **Leaving ISSUE:** `m_valid`=0 and `m_op`=NOOP. `m_opnd` and `m_sel` hold their last values.
- `done` and `err` never assert in the same cycle.
- FIFO pointers wrap modulo DEPTH. `count` ranges over 0..DEPTH.

## Timing
- **Reset values:** `req_ready`=1, `done`=0, `err`=0, `busy`=0, `count`=0, `m_valid`=0, `m_op`=NOOP, `m_opnd`=0, `m_sel`=0. FSM=IDLE, FIFO empty, wait counter 0.
- **Reset mid-operation:** the FIFO is flushed and any in-flight command is abandoned. `done` and `err` are not generated for either.
- **Latency, empty FIFO:** push at edge E0, then pop at E1, then `m_valid` is high from E1.
- **Completion pulse:** with `m_ready` high at E2, `done` is high during the cycle E2–E3.
- **Throughput:**
  - Bus commands: at best one per 2 cycles, because IDLE lasts one cycle.
  - NOOP and bad-channel commands: one per cycle.
- **Timeout edge:** ready arriving on the same edge the counter reaches TIMEOUT counts as completion, not an error.
- **`count`:** reflects pushes and pops made at the previous edge.

## Configuration
- **`TMOD_TIMEOUT_EN` defined:** the ISSUE wait counter and timeout abort are present, as described above.
- **`TMOD_TIMEOUT_EN` undefined:**
  - ISSUE waits indefinitely for ready.
  - `err` is raised only for out-of-range channels.
  - The TIMEOUT parameter is ignored and no counter logic is generated.

## Test plan
- **Basic command:** reset, then push `SET_FRQ`, ch=1, data=0x3C. Hold `m_ready`=2'b10 from that cycle. Expect:
  - `m_valid` for 1 cycle with `m_op`=SET_FRQ, `m_opnd`=0x3C, `m_sel`=2'b10.
  - `done` pulse 2 cycles after the push edge.
- **FIFO full:** hold `m_ready`=0 and push 5 commands with DEPTH=4. Expect:
  - `req_ready`=0 after the 5th push. The 1st command has left for ISSUE.
  - `count`=4.
  - Raising `m_ready` drains all 5 with 5 `done` pulses, in push order.
- **Broadcast RESET:** `m_ready`=2'b01 for 3 cycles, then 2'b11. Expect:
  - `m_sel`=2'b11 held throughout.
  - Exactly one `done` pulse, on the edge after 2'b11 appears.
- **Bad channel and NOOP:** NCH=3; push `SET_HIGH_TEMP` ch=3, then NOOP. Expect:
  - `err` pulse, then `done` pulse on consecutive cycles.
  - `m_valid` never asserted.
- **Timeout** (`TMOD_TIMEOUT_EN`, TIMEOUT=16): hold `m_ready`=0. Expect:
  - `err` pulse after 16 ISSUE cycles.
  - Next command issued 1 cycle later.
  - Without the macro: no `err`, and `m_valid` stays high.
- **Reset mid-ISSUE** with 2 commands queued. Expect:
  - All outputs at reset values the cycle after reset asserts.
  - `count`=0.
  - No `done` or `err` pulse.
